// File: rtl/pi_gain_scheduler.sv
// Gain scheduler for the bang-bang PI loop filter: holds the filter in reset,
// acquires with high gains, tracks with low gains, and recovers from rail faults.
module pi_gain_scheduler #(
    parameter int DAC_W        = 20,
    parameter int SHIFT_W      = 4,
    parameter int KP_ACQ       = 2,
    parameter int KI_ACQ       = 6,
    parameter int KP_TRK       = 5,
    parameter int KI_TRK       = 10,
    parameter int HOLD_CYC     = 4,
    parameter int ACQ_CYCLES   = 64,
    parameter int LOCK_WIN     = 32,
    parameter int LOCK_TOG_MIN = 12,
    parameter int UNLOCK_RUN   = 16,
    parameter int DAC_MARGIN   = 1024,
    parameter int RAIL_CYC     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               x,
    input  logic [DAC_W-1:0]   dac,
    output logic               filt_rst_n,
    output logic [SHIFT_W-1:0] kp_shift,
    output logic [SHIFT_W-1:0] ki_shift,
    output logic               locked,
    output logic [1:0]         state,
    output logic [7:0]         fault_cnt
);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int HOLD_W  = $clog2(HOLD_CYC + 1);
    localparam int DWELL_W = $clog2(ACQ_CYCLES + 1);
    localparam int WIN_W   = $clog2(LOCK_WIN + 1);
    localparam int TOG_W   = $clog2(LOCK_WIN + 1);
    localparam int RUN_W   = $clog2(UNLOCK_RUN + 1);
    localparam int RAIL_W  = $clog2(RAIL_CYC + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX  = DWELL_W'(ACQ_CYCLES);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ACQ_CYCLES - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(LOCK_WIN - 1);
    localparam logic [TOG_W-1:0]   TOG_MIN    = TOG_W'(LOCK_TOG_MIN);
    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(UNLOCK_RUN - 1);
    localparam logic [RAIL_W-1:0]  RAIL_LAST  = RAIL_W'(RAIL_CYC - 1);
    localparam logic [DAC_W-1:0]   RAIL_LO    = DAC_W'(DAC_MARGIN);
    localparam logic [DAC_W-1:0]   RAIL_HI    = DAC_W'((2 ** DAC_W) - 1 - DAC_MARGIN);

    localparam logic [SHIFT_W-1:0] KP_ACQ_V = SHIFT_W'(KP_ACQ);
    localparam logic [SHIFT_W-1:0] KI_ACQ_V = SHIFT_W'(KI_ACQ);
    localparam logic [SHIFT_W-1:0] KP_TRK_V = SHIFT_W'(KP_TRK);
    localparam logic [SHIFT_W-1:0] KI_TRK_V = SHIFT_W'(KI_TRK);

    state_t               state_q,      state_d;
    logic [HOLD_W-1:0]    hold_cnt_q,   hold_cnt_d;
    logic [DWELL_W-1:0]   dwell_cnt_q,  dwell_cnt_d;
    logic [WIN_W-1:0]     win_cnt_q,    win_cnt_d;
    logic [TOG_W-1:0]     tog_cnt_q,    tog_cnt_d;
    logic [RUN_W-1:0]     run_cnt_q,    run_cnt_d;
    logic [RAIL_W-1:0]    rail_cnt_q,   rail_cnt_d;
    logic [7:0]           fault_cnt_q,  fault_cnt_d;
    logic                 x_q,          x_d;
    logic                 filt_rst_n_q, filt_rst_n_d;
    logic [SHIFT_W-1:0]   kp_q,         kp_d;
    logic [SHIFT_W-1:0]   ki_q,         ki_d;
    logic                 locked_q,     locked_d;

    logic                 toggle;
    logic                 near_rail;
    logic                 active;
    logic                 fault;
    logic                 win_end;
    logic                 dwell_met;
    logic [TOG_W-1:0]     tog_sum;
    logic                 lock_ok;
    logic                 unlock;

    // Event detection; everything here looks at the current cycle's inputs.
    always_comb begin
        toggle    = x ^ x_q;
        near_rail = (dac < RAIL_LO) || (dac > RAIL_HI);
        active    = (state_q == ST_ACQ) || (state_q == ST_LOCKED);
        fault     = active && near_rail && (rail_cnt_q == RAIL_LAST);
        win_end   = (win_cnt_q == WIN_LAST);
        dwell_met = (dwell_cnt_q >= DWELL_LAST);
        tog_sum   = tog_cnt_q + TOG_W'(toggle);
        lock_ok   = (state_q == ST_ACQ) && win_end && dwell_met && (tog_sum >= TOG_MIN);
        unlock    = (state_q == ST_LOCKED) && !toggle && (run_cnt_q == RUN_LAST);
    end

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        win_cnt_d   = win_cnt_q;
        tog_cnt_d   = tog_cnt_q;
        run_cnt_d   = run_cnt_q;
        fault_cnt_d = fault_cnt_q;
        x_d         = x;
        rail_cnt_d  = (active && near_rail) ? rail_cnt_q + 1'b1 : '0;

        case (state_q)
            ST_HOLD: begin
                if (!en) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = ST_ACQ;
                    hold_cnt_d  = '0;
                    dwell_cnt_d = '0;
                    win_cnt_d   = '0;
                    tog_cnt_d   = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_ACQ: begin
                dwell_cnt_d = (dwell_cnt_q == DWELL_MAX) ? dwell_cnt_q : dwell_cnt_q + 1'b1;
                win_cnt_d   = win_end ? '0 : win_cnt_q + 1'b1;
                tog_cnt_d   = win_end ? '0 : tog_sum;
                if (lock_ok) begin
                    state_d   = ST_LOCKED;
                    run_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                run_cnt_d = toggle ? '0 : run_cnt_q + 1'b1;
                if (unlock) begin
                    state_d     = ST_ACQ;
                    run_cnt_d   = '0;
                    dwell_cnt_d = '0;
                    win_cnt_d   = '0;
                    tog_cnt_d   = '0;
                end
            end
            default: begin
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
            end
        endcase

        // Disable outranks a rail fault; both outrank the lock/unlock decisions above.
        if (!en) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
            rail_cnt_d = '0;
        end else if (fault) begin
            state_d     = ST_HOLD;
            hold_cnt_d  = '0;
            rail_cnt_d  = '0;
            fault_cnt_d = (fault_cnt_q == 8'hFF) ? fault_cnt_q : fault_cnt_q + 8'd1;
        end

        // Outputs follow the next state so they move on the same edge as state.
        filt_rst_n_d = (state_d != ST_HOLD);
        locked_d     = (state_d == ST_LOCKED);
        kp_d         = (state_d == ST_LOCKED) ? KP_TRK_V : KP_ACQ_V;
        ki_d         = (state_d == ST_LOCKED) ? KI_TRK_V : KI_ACQ_V;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= '0;
            dwell_cnt_q  <= '0;
            win_cnt_q    <= '0;
            tog_cnt_q    <= '0;
            run_cnt_q    <= '0;
            rail_cnt_q   <= '0;
            fault_cnt_q  <= '0;
            x_q          <= 1'b0;
            filt_rst_n_q <= 1'b0;
            kp_q         <= KP_ACQ_V;
            ki_q         <= KI_ACQ_V;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
            win_cnt_q    <= win_cnt_d;
            tog_cnt_q    <= tog_cnt_d;
            run_cnt_q    <= run_cnt_d;
            rail_cnt_q   <= rail_cnt_d;
            fault_cnt_q  <= fault_cnt_d;
            x_q          <= x_d;
            filt_rst_n_q <= filt_rst_n_d;
            kp_q         <= kp_d;
            ki_q         <= ki_d;
            locked_q     <= locked_d;
        end
    end

    assign state      = state_q;
    assign filt_rst_n = filt_rst_n_q;
    assign kp_shift   = kp_q;
    assign ki_shift   = ki_q;
    assign locked     = locked_q;
    assign fault_cnt  = fault_cnt_q;

endmodule

// File: tb/tb_pi_gain_scheduler.sv
// Directed bench for pi_gain_scheduler: stimulus queues expected output snapshots,
// a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_pi_gain_scheduler;

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_ACQ  = 2'd1;
    localparam logic [1:0] S_LOCK = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b1;
    logic        x   = 1'b0;
    logic [19:0] dac = 20'h80000;
    logic        filt_rst_n;
    logic [3:0]  kp_shift;
    logic [3:0]  ki_shift;
    logic        locked;
    logic [1:0]  state;
    logic [7:0]  fault_cnt;
    logic [19:0] actual;

    typedef struct {
        string       name;
        logic [19:0] exp;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;
    int  checks = 0;
    int  errors = 0;
    bit  x_alt  = 1'b0;

    pi_gain_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .x          (x),
        .dac        (dac),
        .filt_rst_n (filt_rst_n),
        .kp_shift   (kp_shift),
        .ki_shift   (ki_shift),
        .locked     (locked),
        .state      (state),
        .fault_cnt  (fault_cnt)
    );

    always #5 clk = ~clk;

    assign actual = {state, filt_rst_n, kp_shift, ki_shift, locked, fault_cnt};

    task automatic expect_out(input string name, input logic [1:0] st, input logic frn,
                              input logic [3:0] kp, input logic [3:0] ki,
                              input logic lk, input logic [7:0] fc);
        sb_t e;
        e.name = name;
        e.exp  = {st, frn, kp, ki, lk, fc};
        sb_q.push_back(e);
    endtask

    // Advance n edges; x flips just after each edge while alternating.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (x_alt) x = ~x;
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (actual !== mon_e.exp) begin
                errors++;
                $display("FAIL %s: got state=%0d frn=%0b kp=%0d ki=%0d locked=%0b fault_cnt=%0d, expected state=%0d frn=%0b kp=%0d ki=%0d locked=%0b fault_cnt=%0d",
                         mon_e.name, actual[19:18], actual[17], actual[16:13], actual[12:9],
                         actual[8], actual[7:0], mon_e.exp[19:18], mon_e.exp[17],
                         mon_e.exp[16:13], mon_e.exp[12:9], mon_e.exp[8], mon_e.exp[7:0]);
            end else begin
                $display("check %s ok: state=%0d frn=%0b kp=%0d ki=%0d locked=%0b fault_cnt=%0d",
                         mon_e.name, actual[19:18], actual[17], actual[16:13], actual[12:9],
                         actual[8], actual[7:0]);
            end
        end
    end

    initial begin
        tick(2);
        expect_out("reset", S_HOLD, 1'b0, 4'd2, 4'd6, 1'b0, 8'd0);

        rst = 1'b1;
        x_alt = 1'b1;
        tick(3);
        expect_out("hold_3cyc", S_HOLD, 1'b0, 4'd2, 4'd6, 1'b0, 8'd0);
        tick(1);
        expect_out("acq_entry", S_ACQ, 1'b1, 4'd2, 4'd6, 1'b0, 8'd0);
        tick(63);
        expect_out("acq_cycle63", S_ACQ, 1'b1, 4'd2, 4'd6, 1'b0, 8'd0);
        tick(1);
        expect_out("lock", S_LOCK, 1'b1, 4'd5, 4'd10, 1'b1, 8'd0);

        // Freezing x: the next edge still sees the last flip, then 16 quiet cycles unlock.
        x_alt = 1'b0;
        tick(16);
        expect_out("run15_locked", S_LOCK, 1'b1, 4'd5, 4'd10, 1'b1, 8'd0);
        tick(1);
        expect_out("unlock", S_ACQ, 1'b1, 4'd2, 4'd6, 1'b0, 8'd0);
        x_alt = 1'b1;
        tick(63);
        expect_out("relock_63", S_ACQ, 1'b1, 4'd2, 4'd6, 1'b0, 8'd0);
        tick(1);
        expect_out("relock", S_LOCK, 1'b1, 4'd5, 4'd10, 1'b1, 8'd0);

        x_alt = 1'b0;
        tick(16);
        expect_out("run15_hold", S_LOCK, 1'b1, 4'd5, 4'd10, 1'b1, 8'd0);
        x = ~x;
        x_alt = 1'b1;
        tick(1);
        expect_out("run15_toggle", S_LOCK, 1'b1, 4'd5, 4'd10, 1'b1, 8'd0);
        tick(20);
        expect_out("run15_after", S_LOCK, 1'b1, 4'd5, 4'd10, 1'b1, 8'd0);

        dac = 20'h00100;
        tick(7);
        expect_out("rail7_locked", S_LOCK, 1'b1, 4'd5, 4'd10, 1'b1, 8'd0);
        tick(1);
        expect_out("fault", S_HOLD, 1'b0, 4'd2, 4'd6, 1'b0, 8'd1);
        dac = 20'h80000;
        tick(3);
        expect_out("fault_hold3", S_HOLD, 1'b0, 4'd2, 4'd6, 1'b0, 8'd1);
        tick(1);
        expect_out("fault_acq", S_ACQ, 1'b1, 4'd2, 4'd6, 1'b0, 8'd1);

        dac = 20'hFFF00;
        tick(7);
        expect_out("near7", S_ACQ, 1'b1, 4'd2, 4'd6, 1'b0, 8'd1);
        dac = 20'h80000;
        tick(1);
        expect_out("near7_clear", S_ACQ, 1'b1, 4'd2, 4'd6, 1'b0, 8'd1);

        // Held at the top rail: one fault per 4 HOLD + 8 ACQ cycles.
        dac = 20'hFFF00;
        tick(8);
        expect_out("fault2", S_HOLD, 1'b0, 4'd2, 4'd6, 1'b0, 8'd2);
        for (int k = 0; k < 252; k++) tick(12);
        expect_out("fault254", S_HOLD, 1'b0, 4'd2, 4'd6, 1'b0, 8'd254);
        tick(12);
        expect_out("fault255", S_HOLD, 1'b0, 4'd2, 4'd6, 1'b0, 8'd255);
        tick(12);
        expect_out("fault_sat", S_HOLD, 1'b0, 4'd2, 4'd6, 1'b0, 8'd255);

        dac = 20'h80000;
        tick(4);
        expect_out("sat_acq", S_ACQ, 1'b1, 4'd2, 4'd6, 1'b0, 8'd255);
        tick(64);
        expect_out("lock_again", S_LOCK, 1'b1, 4'd5, 4'd10, 1'b1, 8'd255);

        en = 1'b0;
        tick(1);
        expect_out("en0", S_HOLD, 1'b0, 4'd2, 4'd6, 1'b0, 8'd255);
        tick(20);
        expect_out("en0_hold", S_HOLD, 1'b0, 4'd2, 4'd6, 1'b0, 8'd255);
        en = 1'b1;
        tick(3);
        expect_out("en1_hold3", S_HOLD, 1'b0, 4'd2, 4'd6, 1'b0, 8'd255);
        tick(1);
        expect_out("en1_acq", S_ACQ, 1'b1, 4'd2, 4'd6, 1'b0, 8'd255);

        x_alt = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick(250);
            expect_out($sformatf("frozen_%0d", k * 250), S_ACQ, 1'b1, 4'd2, 4'd6, 1'b0, 8'd255);
        end

        x_alt = 1'b1;
        tick(70);
        expect_out("lock_before_rst", S_LOCK, 1'b1, 4'd5, 4'd10, 1'b1, 8'd255);

        // Reset pulse placed between edges; monitor samples at the negedge inside it.
        @(posedge clk);
        #2;
        rst = 1'b0;
        expect_out("async_rst", S_HOLD, 1'b0, 4'd2, 4'd6, 1'b0, 8'd0);
        #5;
        rst = 1'b1;
        tick(3);
        expect_out("rst_hold3", S_HOLD, 1'b0, 4'd2, 4'd6, 1'b0, 8'd0);
        tick(1);
        expect_out("rst_acq", S_ACQ, 1'b1, 4'd2, 4'd6, 1'b0, 8'd0);
        tick(63);
        expect_out("rst_acq63", S_ACQ, 1'b1, 4'd2, 4'd6, 1'b0, 8'd0);
        tick(1);
        expect_out("rst_lock", S_LOCK, 1'b1, 4'd5, 4'd10, 1'b1, 8'd0);

        tick(2);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
